// File: rtl/framebuffer_arbiter_pkg.sv
// Shared constants, width helpers and swap-FSM state encoding for the frame
// buffer arbiter.
package fb_pkg;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_PENDING = 1'b1
    } fb_state_e;

    function automatic int word_width(input int segments, input int bitwidth);
        return segments * bitwidth * 3;
    endfunction

    function automatic int addr_width(input int rows, input int columns);
        return 1 + $clog2(rows) + $clog2(columns);
    endfunction

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// Loader, scan-out and RAM signals of the frame buffer arbiter.
// The slave modport is the arbiter's own view of the bundle.
interface framebuffer_arbiter_if
    import fb_pkg::*;
#(
    parameter int SEGMENTS = 1,
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32,
    parameter int BITWIDTH = 8
) ();
    localparam int W  = word_width(SEGMENTS, BITWIDTH);
    localparam int RA = $clog2(ROWS);
    localparam int CA = $clog2(COLUMNS);
    localparam int AW = addr_width(ROWS, COLUMNS);

    logic          ld_wen;
    logic [RA-1:0] ld_wrow;
    logic [CA-1:0] ld_wcol;
    logic [W-1:0]  ld_wdata;
    logic          ld_loaded;
    logic          ld_ready;
    logic          sc_req;
    logic [RA-1:0] sc_row;
    logic [CA-1:0] sc_col;
    logic          sc_frame_end;
    logic          sc_gnt;
    logic          sc_rvalid;
    logic [W-1:0]  sc_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          front_bank;
    logic          swap_pending;
    logic [7:0]    swap_count;
    logic          wr_drop;

    modport slave (
        input  ld_wen, ld_wrow, ld_wcol, ld_wdata, ld_loaded,
        input  sc_req, sc_row, sc_col, sc_frame_end, mem_rdata,
        output ld_ready, sc_gnt, sc_rvalid, sc_rdata,
        output mem_addr, mem_wen, mem_wdata,
        output front_bank, swap_pending, swap_count, wr_drop
    );

    modport master (
        output ld_wen, ld_wrow, ld_wcol, ld_wdata, ld_loaded,
        output sc_req, sc_row, sc_col, sc_frame_end, mem_rdata,
        input  ld_ready, sc_gnt, sc_rvalid, sc_rdata,
        input  mem_addr, mem_wen, mem_wdata,
        input  front_bank, swap_pending, swap_count, wr_drop
    );

endinterface

// File: rtl/framebuffer_arbiter_swap_fsm.sv
// Bank-swap controller: detects the loader's frame-complete edge and swaps
// front/back banks at the next scan-out frame boundary.
module fb_swap_fsm
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_wen_i,
    input  logic       ld_loaded_i,
    input  logic       sc_frame_end_i,
    output logic       accept_o,
    output logic       ld_ready_o,
    output logic       swap_pending_o,
    output logic       front_bank_o,
    output logic [7:0] swap_count_o,
    output logic       wr_drop_o
);

    fb_state_e  state_q;
    logic       loaded_q;
    logic       ready_q;
    logic       pending_q;
    logic       front_q;
    logic [7:0] count_q;
    logic       drop_q;
    logic       loaded_rise_s;

    assign loaded_rise_s = ld_loaded_i & ~loaded_q;

    // Swap state machine with all of its status outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_ACCEPT;
            loaded_q  <= 1'b0;
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
            front_q   <= BANK_A;
            count_q   <= 8'd0;
            drop_q    <= 1'b0;
        end else begin
            loaded_q <= ld_loaded_i;
            case (state_q)
                ST_ACCEPT: begin
                    // A frame end coinciding with the edge is ignored: the swap
                    // waits for the following boundary.
                    if (loaded_rise_s) begin
                        state_q   <= ST_PENDING;
                        ready_q   <= 1'b0;
                        pending_q <= 1'b1;
                    end else begin
                        state_q   <= ST_ACCEPT;
                    end
                end
                ST_PENDING: begin
                    if (ld_wen_i) begin
                        drop_q <= 1'b1;
                    end else begin
                        drop_q <= drop_q;
                    end
                    if (sc_frame_end_i) begin
                        state_q   <= ST_ACCEPT;
                        ready_q   <= 1'b1;
                        pending_q <= 1'b0;
                        front_q   <= (front_q == BANK_A) ? BANK_B : BANK_A;
                        count_q   <= count_q + 8'd1;
                    end else begin
                        state_q   <= ST_PENDING;
                    end
                end
                default: begin
                    state_q   <= ST_ACCEPT;
                    ready_q   <= 1'b1;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign accept_o       = (state_q == ST_ACCEPT);
    assign ld_ready_o     = ready_q;
    assign swap_pending_o = pending_q;
    assign front_bank_o   = front_q;
    assign swap_count_o   = count_q;
    assign wr_drop_o      = drop_q;

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port frame RAM arbiter: loader writes the back bank, scan-out reads
// the front bank; the loader always wins since it cannot be stalled.
module framebuffer_arbiter
    import fb_pkg::*;
#(
    parameter int SEGMENTS = 1,
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32,
    parameter int BITWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    framebuffer_arbiter_if.slave  bus
);

    localparam int W  = word_width(SEGMENTS, BITWIDTH);
    localparam int AW = addr_width(ROWS, COLUMNS);

    logic          accept_s;
    logic          front_s;
    logic          mem_wen_s;
    logic          gnt_s;
    logic [AW-1:0] addr_s;
    logic [W-1:0]  wdata_s;
    logic          rvalid_d;
    logic          rvalid_q;

    fb_swap_fsm u_swap_fsm (
        .clk            (clk),
        .rst            (rst),
        .ld_wen_i       (bus.ld_wen),
        .ld_loaded_i    (bus.ld_loaded),
        .sc_frame_end_i (bus.sc_frame_end),
        .accept_o       (accept_s),
        .ld_ready_o     (bus.ld_ready),
        .swap_pending_o (bus.swap_pending),
        .front_bank_o   (front_s),
        .swap_count_o   (bus.swap_count),
        .wr_drop_o      (bus.wr_drop)
    );

    // Port mux; a dropped write still blocks the read port for that cycle
    always_comb begin
        mem_wen_s = 1'b0;
        gnt_s     = 1'b0;
        addr_s    = {front_s, bus.sc_row, bus.sc_col};
        if (bus.ld_wen) begin
            mem_wen_s = accept_s;
            addr_s    = {~front_s, bus.ld_wrow, bus.ld_wcol};
        end else if (bus.sc_req) begin
            gnt_s     = 1'b1;
        end else begin
            gnt_s     = 1'b0;
        end
    end

    assign wdata_s  = bus.ld_wdata;
    assign rvalid_d = gnt_s;

    // Read data valid tracks the RAM's one-cycle read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.mem_wen    = mem_wen_s;
    assign bus.mem_addr   = addr_s;
    assign bus.mem_wdata  = wdata_s;
    assign bus.sc_gnt     = gnt_s;
    assign bus.sc_rvalid  = rvalid_q;
    assign bus.sc_rdata   = bus.mem_rdata;
    assign bus.front_bank = front_s;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed-vector bench for framebuffer_arbiter with a small frame RAM model.
module tb_framebuffer_arbiter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    framebuffer_arbiter_if bus ();

    framebuffer_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [23:0] ram [0:511];
    logic [23:0] ram_rdata_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
        ram_rdata_r <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = ram_rdata_r;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 512; i++) ram[i] = 24'h000000;
        ram[9'h067] = 24'hABCDEF;
        rst = 1'b0;
        bus.ld_wen = 1'b0; bus.ld_wrow = 3'd0; bus.ld_wcol = 5'd0; bus.ld_wdata = 24'h0;
        bus.ld_loaded = 1'b0; bus.sc_req = 1'b0; bus.sc_row = 3'd0; bus.sc_col = 5'd0;
        bus.sc_frame_end = 1'b0;
        #12;
        check_eq("rst_ready",   {31'd0, bus.ld_ready},     32'd1);
        check_eq("rst_front",   {31'd0, bus.front_bank},   32'd0);
        check_eq("rst_pending", {31'd0, bus.swap_pending}, 32'd0);
        check_eq("rst_rvalid",  {31'd0, bus.sc_rvalid},    32'd0);
        check_eq("rst_count",   {24'd0, bus.swap_count},   32'd0);
        check_eq("rst_drop",    {31'd0, bus.wr_drop},      32'd0);
        rst = 1'b1;
        tick();
        check_eq("idle_wen",  {31'd0, bus.mem_wen}, 32'd0);
        check_eq("idle_gnt",  {31'd0, bus.sc_gnt},  32'd0);
        check_eq("idle_addr", {23'd0, bus.mem_addr}, 32'h000);

        // 1: write into back bank
        bus.ld_wen = 1'b1; bus.ld_wrow = 3'd2; bus.ld_wcol = 5'd5; bus.ld_wdata = 24'h123456;
        #1;
        check_eq("wr_wen",   {31'd0, bus.mem_wen},   32'd1);
        check_eq("wr_addr",  {23'd0, bus.mem_addr},  32'h145);
        check_eq("wr_data",  {8'd0, bus.mem_wdata},  32'h123456);
        check_eq("wr_ready", {31'd0, bus.ld_ready},  32'd1);
        check_eq("wr_front", {31'd0, bus.front_bank}, 32'd0);
        tick();

        // 2: held read loses to a write, then is granted
        bus.ld_wrow = 3'd0; bus.ld_wcol = 5'd0; bus.ld_wdata = 24'h0000AA;
        bus.sc_req = 1'b1; bus.sc_row = 3'd3; bus.sc_col = 5'd7;
        #1;
        check_eq("blk_gnt", {31'd0, bus.sc_gnt},  32'd0);
        check_eq("blk_wen", {31'd0, bus.mem_wen}, 32'd1);
        tick();
        check_eq("blk_rvalid", {31'd0, bus.sc_rvalid}, 32'd0);
        bus.ld_wen = 1'b0;
        #1;
        check_eq("rd_gnt",  {31'd0, bus.sc_gnt},   32'd1);
        check_eq("rd_addr", {23'd0, bus.mem_addr}, 32'h067);
        check_eq("rd_wen",  {31'd0, bus.mem_wen},  32'd0);
        tick();
        bus.sc_req = 1'b0;
        check_eq("rd_rvalid", {31'd0, bus.sc_rvalid}, 32'd1);
        check_eq("rd_rdata",  {8'd0, bus.sc_rdata},   32'hABCDEF);
        tick();
        check_eq("rd_rvalid_end", {31'd0, bus.sc_rvalid}, 32'd0);

        // 3: held ld_loaded schedules one swap only
        bus.ld_loaded = 1'b1;
        #1;
        check_eq("ld_ready_pre", {31'd0, bus.ld_ready}, 32'd1);
        tick();
        check_eq("ld_pending", {31'd0, bus.swap_pending}, 32'd1);
        check_eq("ld_ready",   {31'd0, bus.ld_ready},     32'd0);
        for (int i = 0; i < 9; i++) tick();
        check_eq("ld_pending_hold", {31'd0, bus.swap_pending}, 32'd1);
        bus.sc_frame_end = 1'b1;
        tick();
        bus.sc_frame_end = 1'b0;
        check_eq("sw_front",   {31'd0, bus.front_bank},   32'd1);
        check_eq("sw_count",   {24'd0, bus.swap_count},   32'd1);
        check_eq("sw_ready",   {31'd0, bus.ld_ready},     32'd1);
        check_eq("sw_pending", {31'd0, bus.swap_pending}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check_eq("no_retrig", {31'd0, bus.swap_pending}, 32'd0);
        bus.ld_loaded = 1'b0;
        tick();

        // 4: write while pending is dropped and sticky
        bus.ld_loaded = 1'b1;
        tick();
        bus.ld_loaded = 1'b0;
        check_eq("p4_pending", {31'd0, bus.swap_pending}, 32'd1);
        bus.ld_wen = 1'b1; bus.sc_req = 1'b1;
        #1;
        check_eq("drop_wen", {31'd0, bus.mem_wen}, 32'd0);
        check_eq("drop_gnt", {31'd0, bus.sc_gnt},  32'd0);
        tick();
        bus.ld_wen = 1'b0; bus.sc_req = 1'b0;
        check_eq("drop_flag", {31'd0, bus.wr_drop}, 32'd1);
        bus.sc_frame_end = 1'b1;
        tick();
        bus.sc_frame_end = 1'b0;
        check_eq("p4_front", {31'd0, bus.front_bank}, 32'd0);
        check_eq("p4_count", {24'd0, bus.swap_count}, 32'd2);
        check_eq("drop_sticky", {31'd0, bus.wr_drop}, 32'd1);

        // 5: edge, frame end and write in one cycle
        bus.ld_loaded = 1'b1; bus.sc_frame_end = 1'b1;
        bus.ld_wen = 1'b1; bus.ld_wrow = 3'd1; bus.ld_wcol = 5'd1; bus.ld_wdata = 24'h555555;
        #1;
        check_eq("p5_wen",  {31'd0, bus.mem_wen},  32'd1);
        check_eq("p5_addr", {23'd0, bus.mem_addr}, 32'h121);
        tick();
        bus.ld_loaded = 1'b0; bus.sc_frame_end = 1'b0; bus.ld_wen = 1'b0;
        check_eq("p5_pending", {31'd0, bus.swap_pending}, 32'd1);
        check_eq("p5_front",   {31'd0, bus.front_bank},   32'd0);
        check_eq("p5_count",   {24'd0, bus.swap_count},   32'd2);
        bus.sc_frame_end = 1'b1;
        tick();
        bus.sc_frame_end = 1'b0;
        check_eq("p5_swap_front", {31'd0, bus.front_bank}, 32'd1);
        check_eq("p5_swap_count", {24'd0, bus.swap_count}, 32'd3);

        // 6: asynchronous reset mid-pending
        bus.ld_loaded = 1'b1; bus.sc_req = 1'b1;
        tick();
        check_eq("p6_pending", {31'd0, bus.swap_pending}, 32'd1);
        check_eq("p6_rvalid",  {31'd0, bus.sc_rvalid},    32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_front",   {31'd0, bus.front_bank},   32'd0);
        check_eq("arst_pending", {31'd0, bus.swap_pending}, 32'd0);
        check_eq("arst_ready",   {31'd0, bus.ld_ready},     32'd1);
        check_eq("arst_rvalid",  {31'd0, bus.sc_rvalid},    32'd0);
        check_eq("arst_count",   {24'd0, bus.swap_count},   32'd0);
        check_eq("arst_drop",    {31'd0, bus.wr_drop},      32'd0);
        bus.ld_loaded = 1'b0; bus.sc_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
- Shares one single-port synchronous frame RAM between two requesters: the SPI loader (spi_controller write port) and the LED matrix scan-out engine (read port).
- The RAM holds two banks, front and back. Scan-out always reads the front bank; the loader always writes the back bank.
- On the loader's frame-complete indication, a bank swap is scheduled for the next scan-out frame boundary.
- The block drives the loader's `ready` handshake and sits between spi_controller, the frame RAM and the scan-out engine.

Parameters:
- segments, 1, number of panel segments per column word.
- rows, 8, addressable rows per bank.
- columns, 32, columns per row.
- bitwidth, 8, bits per colour channel.
- Derived, not overridable: W = segments*bitwidth*3; RA = $clog2(rows); CA = $clog2(columns); AW = 1+RA+CA.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ld_wen  in  1  loader write strobe (one cycle per word).
- ld_wrow  in  RA  loader row.
- ld_wcol  in  CA  loader column.
- ld_wdata  in  W  loader word.
- ld_loaded  in  1  loader frame-complete level.
- ld_ready  out  1  back bank writable.
- sc_req  in  1  scan-out read request.
- sc_row  in  RA  scan-out row.
- sc_col  in  CA  scan-out column.
- sc_frame_end  in  1  one-cycle pulse when scan-out finishes the last row.
- sc_gnt  out  1  read issued this cycle.
- sc_rvalid  out  1  read data valid.
- sc_rdata  out  W  read data.
- mem_addr  out  AW  RAM address {bank,row,col}.
- mem_wen  out  1  RAM write enable.
- mem_wdata  out  W  RAM write data.
- mem_rdata  in  W  RAM read data, 1-cycle latency.
- front_bank  out  1  bank currently scanned out.
- swap_pending  out  1  loaded frame waiting for swap.
- swap_count  out  8  completed swaps, wraps 255->0.
- wr_drop  out  1  sticky: a write arrived while swap pending.

Behaviour:
- Reset (rst=0, async) forces front_bank=0, swap_pending=0, ld_ready=1, sc_rvalid=0, swap_count=0, wr_drop=0, and the internal loaded_q=0.
- With ld_wen=0 and sc_req=0 after reset: mem_wen=0, sc_gnt=0, mem_addr={0,sc_row,sc_col}.
- State machine, two states:
  - ACCEPT: ld_ready=1.
  - PENDING: ld_ready=0, swap_pending=1.
  - ACCEPT->PENDING on the rising edge of ld_loaded (ld_loaded & !loaded_q). The edge detect is registered, so ld_loaded held high never re-triggers.
  - PENDING->ACCEPT on sc_frame_end: front_bank toggles, swap_count increments and swap_pending clears, all registered at that edge.
  - sc_frame_end in ACCEPT: no effect.
- Simultaneous events:
  - A ld_loaded rising edge and sc_frame_end in the same cycle enter PENDING; the swap waits for the next sc_frame_end.
  - An ld_wen in the same cycle as the ld_loaded edge is accepted.
- Arbitration is combinational, and the write always wins because the loader has no backpressure.
- Write path:
  - An effective write is ld_wen & (state==ACCEPT).
  - When it occurs: mem_wen=1, mem_addr={~front_bank,ld_wrow,ld_wcol}, mem_wdata=ld_wdata, sc_gnt=0.
- Dropped write:
  - ld_wen in PENDING produces no RAM write and sets wr_drop=1.
  - wr_drop is cleared only by reset.
  - The read port is still blocked that cycle.
- Read path:
  - If ld_wen=0 and sc_req=1: sc_gnt=1, mem_addr={front_bank,sc_row,sc_col}, mem_wen=0.
  - The requester holds sc_req, sc_row and sc_col until it sees sc_gnt.
- Read latency:
  - sc_rvalid is sc_gnt registered, one cycle later; sc_rdata=mem_rdata passthrough.
  - A read granted in the same cycle a swap registers still returns old-bank data, because the address was already issued.
- Throughput:
  - One access per cycle.
  - A continuous sc_req sees sc_gnt low only in cycles with ld_wen.
- Out-of-range row/column values (non-power-of-2 rows/columns) are passed through unchecked.

Decomposition:
- Package fb_pkg holds:
  - constants BANK_A=1'b0 and BANK_B=1'b1;
  - functions word_width(segments,bitwidth) and addr_width(rows,columns);
  - state encodings ST_ACCEPT and ST_PENDING.
- Sub-module fb_swap_fsm owns loaded_q, the two-state FSM, front_bank, swap_count and wr_drop.
- The top level keeps the combinational address/write mux and the sc_rvalid register.

Test Plan:
1. Reset, then write word 0x123456 at row 2, col 5 → mem_wen=1, mem_addr={1,2,5}, ld_ready=1, front_bank=0.
2. Hold sc_req with row 3, col 7, and pulse ld_wen once → sc_gnt low in the ld_wen cycle and high the next; sc_rvalid one cycle after each grant; mem_addr={0,3,7} on grant.
3. Raise ld_loaded and hold it 10 cycles → swap_pending=1 and ld_ready=0 after one edge. Then sc_frame_end → front_bank=1, swap_count=1, ld_ready=1; no second swap while ld_loaded stays high.
4. In PENDING, pulse ld_wen → mem_wen=0, wr_drop=1, wr_drop stays 1 through the swap.
5. ld_loaded rise and sc_frame_end in the same cycle → swap_pending=1, front_bank unchanged; the next sc_frame_end swaps.
6. Assert rst low mid-PENDING, asynchronously between clock edges → front_bank=0, swap_pending=0, ld_ready=1, sc_rvalid=0 immediately; swap_count=0.
